// File: rtl/rs232r_fifo.sv
// rs232r_fifo: RS232 receiver with runtime baud/format, start-glitch rejection, error flags and receive FIFO
module rs232r_fifo #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    RxD,
  input  logic [DIV_W-1:0]        divisor,
  input  logic [1:0]              nbits,
  input  logic [1:0]              pmode,
  input  logic                    done,
  input  logic                    clr_ovr,
  output logic                    rdy,
  output logic [7:0]              data,
  output logic                    perr,
  output logic                    ferr,
  output logic                    ovr,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic q0, q1, fe;
  logic [DIV_W-1:0] div_l, tick;
  logic [1:0] nb_l, pm_l;
  logic [7:0] shreg;
  logic [3:0] bcnt;
  logic perr_r, mid, endt, last, push, pop, wr;
  logic [9:0] entry;
  logic [9:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign mid   = tick == (div_l >> 1);
  assign endt  = tick == div_l;
  assign last  = bcnt == {2'b00, nb_l} + 4'd5;
  assign entry = {~q1, perr_r, shreg >> (2'd3 - nb_l)};
  assign push  = state == STOP && mid;
  assign pop   = done && rdy;
  assign wr    = push && (!count[AW] || pop);
  assign rdy   = count != '0;
  assign {ferr, perr, data} = rdy ? mem[rp] : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fe ? START : IDLE;
      START:   state_n = (mid && q1) ? IDLE : endt ? DATA : START;
      DATA:    state_n = !(endt && last) ? DATA : pm_l[1] ? PARITY : STOP;
      PARITY:  state_n = endt ? STOP : PARITY;
      STOP:    state_n = mid ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q0     <= 1'b1;
      q1     <= 1'b1;
      fe     <= 1'b0;
      state  <= IDLE;
      tick   <= '0;
      div_l  <= '0;
      nb_l   <= '0;
      pm_l   <= '0;
      shreg  <= '0;
      bcnt   <= '0;
      perr_r <= 1'b0;
    end else begin
      q0    <= RxD;
      q1    <= q0;
      fe    <= q1 && !q0;
      state <= state_n;
      tick  <= (state == IDLE || endt) ? '0 : tick + 1'b1;
      if (state == IDLE && fe) begin
        div_l  <= divisor;
        nb_l   <= nbits;
        pm_l   <= pmode;
        shreg  <= '0;
        bcnt   <= '0;
        perr_r <= 1'b0;
      end
      if (state == DATA && mid) begin
        shreg <= {q1, shreg[7:1]};
        bcnt  <= bcnt + 1'b1;
      end
      if (state == PARITY && mid) perr_r <= ^shreg ^ q1 ^ pm_l[0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovr   <= 1'b0;
    end else begin
      wp    <= wp + AW'(wr);
      rp    <= rp + AW'(pop);
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
      ovr   <= (ovr && !clr_ovr) || (push && !wr);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= entry;
  end
endmodule

// File: doc/rs232r_fifo.md
# rs232r_fifo

Parametrised RS232 receiver: runtime baud divisor, 5–8 data bits, optional even/odd parity, start-bit glitch rejection, framing/parity error flags and a receive FIFO with sticky overrun. It sits between the board RxD pin and the I/O bus. It replaces the fixed two-rate, 8-bit, single-buffer receiver wherever the CPU cannot service each byte within one character time.

## Interface
- DEPTH, 16: FIFO entries; power of 2, at least 2.
- DIV_W, 16: width of the divisor input.
- clk, in, 1: system clock.
- rst, in, 1: reset. Synchronous, active-high.
- RxD, in, 1: serial line, asynchronous, idle high.
- divisor, in, DIV_W: clocks per bit minus 1; must be at least 3. Example: 216 gives 115200 bps at 25 MHz.
- nbits, in, 2: data bits minus 5 (0=5 … 3=8).
- pmode, in, 2: parity mode. 0 and 1 = none, 2 = even, 3 = odd.
- done, in, 1: pop the head entry. Ignored when rdy=0.
- clr_ovr, in, 1: clear the overrun flag.
- rdy, out, 1: FIFO not empty.
- data, out, 8: head entry data, right-aligned, upper bits 0.
- perr, out, 1: head entry parity error.
- ferr, out, 1: head entry framing error (stop bit sampled 0).
- ovr, out, 1: sticky overrun.
- count, out, $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Synchroniser: RxD passes through 2 flops, Q0 then Q1, both reset to 1. A falling edge is Q1=1 & Q0=0.
- Configuration: divisor, nbits and pmode are latched on the cycle the falling edge is accepted in IDLE. Changes mid-frame have no effect on the frame in progress.
- Bit timer: `tick` counts 0..div_l. endtick is tick==div_l, after which tick returns to 0. midtick is tick==div_l>>1.
- State machine (IDLE, START, DATA, PARITY, STOP):
  - IDLE: on a falling edge, clear tick and go to START.
  - START: at midtick, if Q1=1 the start is false; return to IDLE with no FIFO write. Otherwise, at endtick go to DATA.
  - DATA: at each midtick, shift Q1 in at bit 7 (LSB first). After nbits+5 bits, at endtick go to PARITY if parity is enabled, else STOP.
  - PARITY: at midtick, compute perr. For even parity, the XOR of data and parity bit must be 0; for odd parity, it must be 1. At endtick go to STOP.
  - STOP: at midtick, set ferr = ~Q1, write the entry and go to IDLE directly, without waiting for endtick. The machine can therefore catch a back-to-back start edge.
- Alignment: stored data = shreg >> (3 - nbits).
- FIFO entry is {ferr, perr, data[7:0]}. The outputs show the head entry combinationally from storage and are 0 when empty.
- Push when full: if done is asserted in the same cycle, pop and push both happen and count is unchanged. Otherwise the new frame is dropped, ovr is set, and the existing entries are unchanged.
- Push and pop in the same cycle when not empty: count is unchanged. Pointers wrap modulo DEPTH.
- ovr stays set until clr_ovr. If clr_ovr and a new overrun occur in the same cycle, ovr stays set.
- A break (line held low) produces an entry with data=0 and ferr=1. The receiver then waits in IDLE for the line to return high before detecting a new falling edge.

## Timing
- Reset values:
  - rdy=0, data=0, perr=0, ferr=0, ovr=0, count=0.
  - State is IDLE, tick=0, FIFO empty, Q0=Q1=1.
- Reset mid-frame aborts the frame, flushes the FIFO and clears ovr on the next edge. No entry comes from the partial frame.
- Edge-to-start latency: RxD low to the first START cycle is 3 clocks (2 synchroniser stages plus the edge register).
- Write latency: rdy and count update on the clock after the STOP midtick cycle.
- Pop: done is sampled at the clock edge. The next entry, or empty, is visible the following cycle. Holding done high pops one entry per clock.
- Sampling points: each bit is sampled at tick = div_l>>1 after its boundary. A frame occupies (1 + nbits + 5 + parity + 0.5)·(div_l+1) clocks, plus the 3-clock edge latency.

## Test plan
- 8N1 framing (divisor=216, nbits=3, pmode=0): send 0x55 → rdy=1, data=0x55, perr=0, ferr=0, count=1. Pulse done → rdy=0 next cycle.
- 7E1 parity (nbits=2, pmode=2): send 0x41 with correct parity → data=0x41, perr=0. Send 0x41 with the parity bit flipped → perr=1.
- Start glitch: RxD low for 0.3 bit time → no entry, state returns to IDLE. Then send 0xA3 → data=0xA3.
- Framing error: 0x0F with stop bit 0 → ferr=1, data=0x0F. Then a full break → data=0x00, ferr=1, and only one entry.
- Overrun (DEPTH=16): send 17 bytes 0x00..0x10 with no pops → count=16, ovr=1, head=0x00, 0x10 lost. Pop and push in the same cycle when full → count stays 16. clr_ovr → ovr=0.
- Reset mid-frame: assert rst for one cycle during DATA with 3 entries queued → count=0, rdy=0, ovr=0, no entry from the partial frame. The next full frame is received correctly.
